// File: rtl/fp16_pkg.sv
// fp16_pkg -- shared definitions for the half-precision FP units.
//   Field widths/positions, exponent constants, canonical special encodings,
//   and the state enum used by the multi-cycle FP units.
package fp16_pkg;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int SIGN_POS = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;

    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] INF  = 16'h7C00;
    localparam logic [15:0] QNAN = 16'h7E00;

    // Working mantissa: carry, hidden, 10 fraction bits, guard, round.
    localparam int DP_W      = 14;
    // Past this many alignment shifts every bit of B sits in sticky.
    localparam int MAX_SHIFT = 14;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        PACK,
        DONE
    } fp_state_e;
endpackage

// File: rtl/fp16_classify.sv
// fp16_classify -- combinational unpack of one half-precision operand.
//   value    : raw 16-bit operand
//   sign     : sign bit
//   exp      : biased exponent
//   mant     : mantissa with hidden bit (hidden bit is 0 for zeros)
//   is_zero  : exponent field is 0 (no subnormals, fraction ignored)
//   is_inf   : exponent field is 31 (fraction ignored, no NaN class)
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]      value,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   mant,
    output logic             is_zero,
    output logic             is_inf
);
    assign sign    = value[SIGN_POS];
    assign exp     = value[EXP_MSB:EXP_LSB];
    assign is_zero = (exp == '0);
    assign is_inf  = (exp == EXP_W'(EXP_MAX));
    assign mant    = {~is_zero, value[MAN_W-1:0]};
endmodule

// File: rtl/fp16_sub_seq.sv
// fp16_sub_seq -- iterative half-precision subtractor, result = op1 - op2.
//   One alignment or normalization bit per cycle; one operation in flight.
//   clk, rst        : clock, asynchronous active-high reset
//   op_valid/ready  : operand handshake (ready only while idle)
//   op1, op2        : minuend, subtrahend
//   res_valid/ready : result handshake (result held until taken)
//   result          : registered difference
//   ovf             : result saturated to infinity
//   unf             : result flushed to zero by underflow
// Build option: define FPSUB_RNE_EN for round-to-nearest-even; otherwise the
// result is truncated toward zero. Latency is the same in both builds.
module fp16_sub_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        ovf,
    output logic        unf
);
    fp_state_e state, state_nxt;

    logic [15:0]      op1_q, op2_q;
    logic             sgn;          // sign of the larger-magnitude operand
    logic [5:0]       exp_r;        // one spare bit for the carry into 31
    logic [DP_W-1:0]  ma, mb;       // ma becomes the sum after ADD
    logic             stk;
    logic [3:0]       cnt;
    logic             eff_sub;
    logic             special_r;
    logic [15:0]      special_val;
    logic             unf_r;

    // ---------------- operand classification ----------------
    logic             s1, s2, z1, z2, i1, i2;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W:0]   m1, m2;

    fp16_classify u_cls1 (.value(op1_q), .sign(s1), .exp(e1), .mant(m1),
                          .is_zero(z1), .is_inf(i1));
    fp16_classify u_cls2 (.value(op2_q), .sign(s2), .exp(e2), .mant(m2),
                          .is_zero(z2), .is_inf(i2));

    // ---------------- UNPACK combinational ----------------
    logic             sb;           // subtrahend sign after negation
    logic             swap;
    logic [EXP_W-1:0] ea, eb, d;
    logic [MAN_W:0]   mant_a, mant_b;
    logic [3:0]       d_clip;
    logic             is_special;
    logic [15:0]      spec_val;

    always_comb begin
        sb     = ~s2;
        swap   = (op2_q[14:0] > op1_q[14:0]);
        ea     = swap ? e2 : e1;
        eb     = swap ? e1 : e2;
        mant_a = swap ? m2 : m1;
        mant_b = swap ? m1 : m2;
        d      = ea - eb;
        d_clip = (d > EXP_W'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : d[3:0];

        is_special = i1 | i2 | z1 | z2;
        spec_val   = 16'h0000;
        if (i1 && i2)
            // Both infinite: same raw signs means an effective inf - inf.
            spec_val = (s1 == s2) ? QNAN : {s1, INF[14:0]};
        else if (i1)
            spec_val = {s1, INF[14:0]};
        else if (i2)
            spec_val = {sb, INF[14:0]};
        else if (z1 && z2)
            spec_val = 16'h0000;
        else if (z1)
            spec_val = {sb, op2_q[14:0]};
        else if (z2)
            spec_val = op1_q;
    end

    // ---------------- ADD combinational ----------------
    // Sticky rides along as an extra LSB so a subtract borrows from it.
    logic [DP_W:0] add_res;
    always_comb begin
        if (eff_sub)
            add_res = {ma, 1'b0} - {mb, stk};
        else
            add_res = {ma, 1'b0} + {mb, stk};
    end

    // ---------------- PACK combinational ----------------
    logic          rnd_up;
    logic [11:0]   rounded;
    logic [5:0]    exp_fin;

    always_comb begin
`ifdef FPSUB_RNE_EN
        rnd_up = ma[1] & (ma[0] | stk | ma[2]);
`else
        rnd_up = 1'b0;
`endif
        rounded = {1'b0, ma[12:2]} + 12'(rnd_up);
        // A rounding carry leaves 10.000..0; shifting right keeps fraction 0.
        exp_fin = exp_r + 6'(rounded[11]);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (op_valid) state_nxt = UNPACK;
            UNPACK: begin
                if (is_special)       state_nxt = PACK;
                else if (d_clip != 0) state_nxt = ALIGN;
                else                  state_nxt = ADD;
            end
            ALIGN:  if (cnt == 4'd1) state_nxt = ADD;
            ADD: begin
                if (add_res == '0)                     state_nxt = PACK;
                else if (add_res[14] || !add_res[13])  state_nxt = NORM;
                else                                   state_nxt = PACK;
            end
            NORM: begin
                if (ma[13])             state_nxt = PACK;
                else if (exp_r == 6'd1) state_nxt = PACK;
                else if (ma[11])        state_nxt = PACK;  // this shift sets hidden
            end
            PACK:   state_nxt = DONE;
            DONE:   if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        op_ready  = (state == IDLE);
        res_valid = (state == DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q       <= '0;
            op2_q       <= '0;
            sgn         <= 1'b0;
            exp_r       <= '0;
            ma          <= '0;
            mb          <= '0;
            stk         <= 1'b0;
            cnt         <= '0;
            eff_sub     <= 1'b0;
            special_r   <= 1'b0;
            special_val <= '0;
            unf_r       <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    op1_q <= op1;
                    op2_q <= op2;
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                end
                UNPACK: begin
                    sgn         <= swap ? sb : s1;
                    exp_r       <= {1'b0, ea};
                    ma          <= {1'b0, mant_a, 2'b00};
                    mb          <= {1'b0, mant_b, 2'b00};
                    stk         <= 1'b0;
                    cnt         <= d_clip;
                    eff_sub     <= (s1 != sb);
                    special_r   <= is_special;
                    special_val <= spec_val;
                    unf_r       <= 1'b0;
                end
                ALIGN: begin
                    mb  <= mb >> 1;
                    stk <= stk | mb[0];
                    cnt <= cnt - 4'd1;
                end
                ADD: begin
                    ma  <= add_res[DP_W:1];
                    stk <= add_res[0];
                    if (add_res == '0) begin
                        special_r   <= 1'b1;
                        special_val <= 16'h0000;
                    end
                end
                NORM: begin
                    if (ma[13]) begin
                        ma    <= ma >> 1;
                        stk   <= stk | ma[0];
                        exp_r <= exp_r + 6'd1;
                    end else if (exp_r == 6'd1) begin
                        unf_r <= 1'b1;
                    end else begin
                        ma    <= {ma[12:0], 1'b0};
                        exp_r <= exp_r - 6'd1;
                    end
                end
                PACK: begin
                    if (special_r) begin
                        result <= special_val;
                    end else if (unf_r) begin
                        result <= 16'h0000;
                        unf    <= 1'b1;
                    end else if (exp_fin >= 6'(EXP_MAX)) begin
                        result <= {sgn, INF[14:0]};
                        ovf    <= 1'b1;
                    end else begin
                        result <= {sgn, exp_fin[4:0],
                                   rounded[11] ? rounded[10:1] : rounded[9:0]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
